alu_issue_ctrl: RTL and testbench

- Issue controller placed directly upstream of the ALU.
- Accepts a command (MODE/CMD/CIN) and operands A and B on three independent valid/ready channels, then drives the ALU input bus (CE, MODE, CMD, OPA, OPB, CIN, INP_VALID).
- Enforces the ALU input protocol: partial-operand presentation, CMD/MODE stability until operands complete, a 16-cycle completion window, and no new issue during multiply latency.

---
 rtl/alu_issue_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue controller ahead of the ALU: collects command + operands and drives the ALU input bus.
// Latency: accept -> COLLECT -> ISSUE, at least 3 cycles per command; multiplies add MUL_LAT-1 idle cycles.
// Backpressure: one command in flight; CMD/A/B READY are decoded only from internal state, never from inputs.
module alu_issue_ctrl #(
    parameter int WIDTH   = 8,
    parameter int C_WIDTH = 4,
    parameter int TIMEOUT = 16,
    parameter int MUL_LAT = 3
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CMD_VALID,
    output logic               CMD_READY,
    input  logic               CMD_MODE,
    input  logic [C_WIDTH-1:0] CMD_OP,
    input  logic               CMD_CIN,
    input  logic               A_VALID,
    output logic               A_READY,
    input  logic [WIDTH-1:0]   A_DATA,
    input  logic               B_VALID,
    output logic               B_READY,
    input  logic [WIDTH-1:0]   B_DATA,
    output logic               CE,
    output logic               MODE,
    output logic [C_WIDTH-1:0] CMD,
    output logic [WIDTH-1:0]   OPA,
    output logic [WIDTH-1:0]   OPB,
    output logic               CIN,
    output logic [1:0]         INP_VALID,
    output logic               TIMEOUT_ERR,
    output logic               BUSY
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int MW = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_ISSUE, S_MUL_WAIT} state_t;

    state_t             state, state_nxt;
    logic               run;
    logic               mode_q, cin_q;
    logic [C_WIDTH-1:0] op_q;
    logic [1:0]         need, held, held_nxt;
    logic [TW-1:0]      timer;
    logic [MW-1:0]      mcnt;
    logic               tmo, tmo_nxt;
    logic               cmd_hs, a_hs, b_hs, partial, is_mul;
    logic               mode_r, cin_r;
    logic [C_WIDTH-1:0] cmd_r;
    logic [WIDTH-1:0]   opa_r, opb_r;

    // Operand-need mask (bit0 = A, bit1 = B); unknown codes fall through to two operands.
    function automatic logic [1:0] need_of(input logic m, input logic [C_WIDTH-1:0] op);
        logic [1:0] n;
        n = 2'b11;
        if (m) begin
            if (op == C_WIDTH'(4) || op == C_WIDTH'(5))
                n = 2'b01;
            else if (op == C_WIDTH'(6) || op == C_WIDTH'(7))
                n = 2'b10;
        end else begin
            if (op == C_WIDTH'(6) || op == C_WIDTH'(8) || op == C_WIDTH'(9))
                n = 2'b01;
            else if (op == C_WIDTH'(7) || op == C_WIDTH'(10) || op == C_WIDTH'(11))
                n = 2'b10;
        end
        return n;
    endfunction

    // run gates CMD_READY so nothing is accepted while reset is (or was just) active.
    assign CMD_READY = run && (state == S_IDLE);
    assign A_READY   = (state == S_COLLECT) && need[0] && !held[0];
    assign B_READY   = (state == S_COLLECT) && need[1] && !held[1];
    assign cmd_hs    = CMD_VALID && CMD_READY;
    assign a_hs      = A_VALID && A_READY;
    assign b_hs      = B_VALID && B_READY;
    assign held_nxt  = held | {b_hs, a_hs};
    // Partial presentation: two-operand command with exactly one operand captured.
    assign partial   = (state == S_COLLECT) && (need == 2'b11) && (held[0] ^ held[1]);
    assign is_mul    = mode_q && (op_q == C_WIDTH'(9) || op_q == C_WIDTH'(10));

    assign CE          = run;
    assign MODE        = mode_r;
    assign CMD         = cmd_r;
    assign CIN         = cin_r;
    assign OPA         = opa_r;
    assign OPB         = opb_r;
    assign INP_VALID   = (state == S_ISSUE) ? need : (partial ? held : 2'b00);
    assign TIMEOUT_ERR = tmo;
    assign BUSY        = (state != S_IDLE);

    // State register.
    always_ff @(posedge CLK) begin
        if (RST)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state decode, including the partial-presentation timeout.
    always_comb begin
        state_nxt = state;
        tmo_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_hs)
                    state_nxt = S_COLLECT;
            end
            S_COLLECT: begin
                if ((held_nxt & need) == need) begin
                    state_nxt = S_ISSUE;
                end else if (partial && timer == TW'(TIMEOUT - 1)) begin
                    state_nxt = S_IDLE;
                    tmo_nxt   = 1'b1;
                end
            end
            S_ISSUE: begin
                state_nxt = (is_mul && MUL_LAT > 1) ? S_MUL_WAIT : S_IDLE;
            end
            S_MUL_WAIT: begin
                if (mcnt == MW'(MUL_LAT - 2))
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Command latch, held flags, partial timer, multiply wait counter and error pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            run    <= 1'b0;
            tmo    <= 1'b0;
            mode_q <= 1'b0;
            op_q   <= '0;
            cin_q  <= 1'b0;
            need   <= 2'b00;
            held   <= 2'b00;
            timer  <= '0;
            mcnt   <= '0;
        end else begin
            run <= 1'b1;
            tmo <= tmo_nxt;
            if (cmd_hs) begin
                mode_q <= CMD_MODE;
                op_q   <= CMD_OP;
                cin_q  <= CMD_CIN;
                need   <= need_of(CMD_MODE, CMD_OP);
                held   <= 2'b00;
                timer  <= '0;
            end else if (state == S_COLLECT) begin
                held <= tmo_nxt ? 2'b00 : held_nxt;
                if (partial)
                    timer <= timer + TW'(1);
            end
            if (state == S_ISSUE)
                mcnt <= '0;
            else if (state == S_MUL_WAIT)
                mcnt <= mcnt + MW'(1);
        end
    end

    // ALU-facing registers: command fields move only when an operand is captured, so they
    // stay frozen whenever INP_VALID is 00.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mode_r <= 1'b0;
            cmd_r  <= '0;
            cin_r  <= 1'b0;
            opa_r  <= '0;
            opb_r  <= '0;
        end else begin
            if (a_hs)
                opa_r <= A_DATA;
            if (b_hs)
                opb_r <= B_DATA;
            if (a_hs || b_hs) begin
                mode_r <= mode_q;
                cmd_r  <= op_q;
                cin_r  <= cin_q;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed scenarios plus randomized commands.
// Expected bus behaviour per command is derived from operand arrival times.
// Inputs change #1 after posedge; outputs are sampled on negedge.
module tb_alu_issue_ctrl;

    localparam int W       = 8;
    localparam int CW      = 4;
    localparam int TMO     = 16;
    localparam int MUL_LAT = 3;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          CMD_VALID = 1'b0, CMD_READY;
    logic          CMD_MODE = 1'b0;
    logic [CW-1:0] CMD_OP = '0;
    logic          CMD_CIN = 1'b0;
    logic          A_VALID = 1'b0, A_READY;
    logic [W-1:0]  A_DATA = '0;
    logic          B_VALID = 1'b0, B_READY;
    logic [W-1:0]  B_DATA = '0;
    logic          CE, MODE, CIN, TIMEOUT_ERR, BUSY;
    logic [CW-1:0] CMD;
    logic [W-1:0]  OPA, OPB;
    logic [1:0]    INP_VALID;

    int n_cmp = 0;
    int n_bad = 0;

    // Model of the ALU-facing registers.
    logic [W-1:0]  exp_opa, exp_opb;
    logic [CW-1:0] exp_cmd;
    logic          exp_mode, exp_cin;

    alu_issue_ctrl #(.WIDTH(W), .C_WIDTH(CW), .TIMEOUT(TMO), .MUL_LAT(MUL_LAT)) dut (
        .CLK(CLK), .RST(RST),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_MODE(CMD_MODE),
        .CMD_OP(CMD_OP), .CMD_CIN(CMD_CIN),
        .A_VALID(A_VALID), .A_READY(A_READY), .A_DATA(A_DATA),
        .B_VALID(B_VALID), .B_READY(B_READY), .B_DATA(B_DATA),
        .CE(CE), .MODE(MODE), .CMD(CMD), .OPA(OPA), .OPB(OPB), .CIN(CIN),
        .INP_VALID(INP_VALID), .TIMEOUT_ERR(TIMEOUT_ERR), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of run, want end before time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_clear();
        exp_opa = '0; exp_opb = '0; exp_cmd = '0; exp_mode = 1'b0; exp_cin = 1'b0;
    endtask

    // Operand-need table: 01 = A only, 10 = B only, 11 = both.
    function automatic logic [1:0] model_need(input logic m, input int op);
        if (m) begin
            if (op inside {4, 5}) return 2'b01;
            if (op inside {6, 7}) return 2'b10;
        end else begin
            if (op inside {6, 8, 9}) return 2'b01;
            if (op inside {7, 10, 11}) return 2'b10;
        end
        return 2'b11;
    endfunction

    // One command: A offered only in collect cycle ta, B only in cycle tb (cycle 0 = first
    // cycle after accept). noise keeps any unneeded operand valid throughout and offers junk
    // operands during the accept cycle.
    task automatic run_txn(input logic m, input int op, input logic cin,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input int ta, input int tb, input logic noise);
        logic [1:0]    nd, early, exp_iv;
        logic          tmo, mul, drive_a, drive_b;
        int            first, last, issue_k, end_k;
        logic [W-1:0]  p_opa;
        logic [CW-1:0] p_cmd;
        nd    = model_need(m, op);
        mul   = m && (op == 9 || op == 10);
        tmo   = 1'b0;
        first = 0;
        last  = 0;
        early = 2'b00;
        if (nd == 2'b11) begin
            first   = (ta < tb) ? ta : tb;
            last    = (ta < tb) ? tb : ta;
            early   = (ta < tb) ? 2'b01 : ((tb < ta) ? 2'b10 : 2'b11);
            tmo     = (last - first) > TMO;
            issue_k = last + 1;
        end else begin
            issue_k = ((nd == 2'b01) ? ta : tb) + 1;
        end
        end_k   = tmo ? first + TMO + 1 : issue_k + 1 + (mul ? MUL_LAT - 1 : 0);
        drive_a = nd[0] && !(tmo && ta > tb);
        drive_b = nd[1] && !(tmo && tb > ta);
        p_opa   = exp_opa;
        p_cmd   = exp_cmd;

        CMD_VALID = 1'b1; CMD_MODE = m; CMD_OP = CW'(op); CMD_CIN = cin;
        A_VALID = noise; A_DATA = ~a; B_VALID = noise; B_DATA = ~b;
        @(negedge CLK);
        n_cmp++;
        if (CMD_READY !== 1'b1) begin
            n_bad++;
            $display("FAIL cmd_ready_idle op=%0d: got %b want 1", op, CMD_READY);
        end
        tick();
        CMD_VALID = 1'b0;
        CMD_MODE = 1'($urandom); CMD_OP = CW'($urandom); CMD_CIN = 1'($urandom);

        for (int k = 0; k <= end_k; k++) begin
            A_VALID = drive_a ? (k == ta) : (!nd[0] && noise);
            A_DATA  = (drive_a && k == ta) ? a : W'($urandom);
            B_VALID = drive_b ? (k == tb) : (!nd[1] && noise);
            B_DATA  = (drive_b && k == tb) ? b : W'($urandom);
            @(negedge CLK);

            exp_iv = 2'b00;
            if (!tmo && k == issue_k)
                exp_iv = nd;
            else if (nd == 2'b11 && early != 2'b11 && k > first && k <= (tmo ? first + TMO : last))
                exp_iv = early;

            n_cmp++;
            if (INP_VALID !== exp_iv) begin
                n_bad++;
                $display("FAIL inp_valid op=%0d k=%0d: got %b want %b", op, k, INP_VALID, exp_iv);
            end
            n_cmp++;
            if (BUSY !== (k < end_k)) begin
                n_bad++;
                $display("FAIL busy op=%0d k=%0d: got %b want %b", op, k, BUSY, k < end_k);
            end
            n_cmp++;
            if (CMD_READY !== (k == end_k)) begin
                n_bad++;
                $display("FAIL cmd_ready op=%0d k=%0d: got %b want %b", op, k, CMD_READY, k == end_k);
            end
            n_cmp++;
            if (TIMEOUT_ERR !== (tmo && k == end_k)) begin
                n_bad++;
                $display("FAIL timeout_err op=%0d k=%0d: got %b want %b", op, k, TIMEOUT_ERR,
                         tmo && k == end_k);
            end
            if (noise && !nd[0]) begin
                n_cmp++;
                if (A_READY !== 1'b0) begin
                    n_bad++;
                    $display("FAIL a_ready_unneeded op=%0d k=%0d: got %b want 0", op, k, A_READY);
                end
            end
            if (noise && !nd[1]) begin
                n_cmp++;
                if (B_READY !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b_ready_unneeded op=%0d k=%0d: got %b want 0", op, k, B_READY);
                end
            end
            if (k == 0) begin
                n_cmp++;
                if (OPA !== p_opa || CMD !== p_cmd) begin
                    n_bad++;
                    $display("FAIL hold_at_accept op=%0d: got opa=%h cmd=%0d want opa=%h cmd=%0d",
                             op, OPA, CMD, p_opa, p_cmd);
                end
            end
            if (exp_iv != 2'b00) begin
                n_cmp++;
                if (MODE !== m || CMD !== CW'(op) || CIN !== cin) begin
                    n_bad++;
                    $display("FAIL cmd_fields k=%0d: got mode=%b cmd=%0d cin=%b want %b %0d %b",
                             k, MODE, CMD, CIN, m, op, cin);
                end
            end
            if (!tmo && k == issue_k) begin
                n_cmp++;
                if (OPA !== exp_opa || OPB !== exp_opb) begin
                    n_bad++;
                    $display("FAIL operands op=%0d: got %h/%h want %h/%h", op, OPA, OPB,
                             exp_opa, exp_opb);
                end
            end

            if ((drive_a && k == ta) || (drive_b && k == tb)) begin
                exp_mode = m; exp_cmd = CW'(op); exp_cin = cin;
            end
            if (drive_a && k == ta) exp_opa = a;
            if (drive_b && k == tb) exp_opb = b;
            if (k == end_k) begin
                A_VALID = 1'b0;
                B_VALID = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        @(negedge CLK);
        n_cmp++;
        if ({CE, INP_VALID, MODE, CMD, OPA, OPB, CIN, CMD_READY, A_READY, B_READY,
             TIMEOUT_ERR, BUSY} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got ce=%b iv=%b cmd=%0d opa=%h opb=%h rdy=%b%b%b busy=%b want all 0",
                     CE, INP_VALID, CMD, OPA, OPB, CMD_READY, A_READY, B_READY, BUSY);
        end
        tick();
        RST = 1'b0;
        tick();
        @(negedge CLK);
        n_cmp++;
        if (CE !== 1'b1) begin
            n_bad++;
            $display("FAIL ce_after_reset: got %b want 1", CE);
        end
        n_cmp++;
        if (CMD_READY !== 1'b1 || BUSY !== 1'b0 || INP_VALID !== 2'b00) begin
            n_bad++;
            $display("FAIL idle_after_reset: got rdy=%b busy=%b iv=%b want 1 0 00",
                     CMD_READY, BUSY, INP_VALID);
        end
        tick();
        model_clear();
    endtask

    task automatic test_two_operand_add();
        run_txn(1'b1, 0, 1'b0, 8'h12, 8'h34, 0, 0, 1'b0);
    endtask

    task automatic test_partial_then_complete();
        run_txn(1'b0, 1, 1'b1, 8'hC3, 8'h5E, 0, 5, 1'b0);
    endtask

    task automatic test_timeout();
        run_txn(1'b1, 0, 1'b0, 8'h77, 8'h99, 40, 0, 1'b0);
    endtask

    task automatic test_single_and_mul();
        run_txn(1'b1, 4, 1'b1, 8'h21, 8'hEE, 1, 0, 1'b1);
        run_txn(1'b1, 9, 1'b0, 8'h03, 8'h05, 0, 0, 1'b0);
    endtask

    task automatic test_reset_mid_collect();
        CMD_VALID = 1'b1; CMD_MODE = 1'b0; CMD_OP = 4'd1; CMD_CIN = 1'b1;
        tick();
        CMD_VALID = 1'b0;
        A_VALID = 1'b1; A_DATA = 8'hA5;
        tick();
        A_VALID = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (INP_VALID !== 2'b01 || OPA !== 8'hA5) begin
            n_bad++;
            $display("FAIL partial_before_reset: got iv=%b opa=%h want 01 a5", INP_VALID, OPA);
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if ({CE, INP_VALID, MODE, CMD, OPA, OPB, CIN, CMD_READY, A_READY, B_READY,
             TIMEOUT_ERR, BUSY} !== '0) begin
            n_bad++;
            $display("FAIL mid_reset_outputs: got ce=%b iv=%b cmd=%0d opa=%h tmo=%b busy=%b want all 0",
                     CE, INP_VALID, CMD, OPA, TIMEOUT_ERR, BUSY);
        end
        tick();
        @(negedge CLK);
        n_cmp++;
        if (TIMEOUT_ERR !== 1'b0 || CMD_READY !== 1'b1) begin
            n_bad++;
            $display("FAIL after_mid_reset: got tmo=%b rdy=%b want 0 1", TIMEOUT_ERR, CMD_READY);
        end
        tick();
        model_clear();
        run_txn(1'b1, 0, 1'b1, 8'h5A, 8'h3C, 1, 1, 1'b0);
    endtask

    task automatic test_random();
        logic m;
        int   op;
        for (int i = 0; i < 40; i++) begin
            m  = 1'($urandom);
            op = $urandom_range(0, 15);
            run_txn(m, op, 1'($urandom), W'($urandom), W'($urandom),
                    $urandom_range(0, 20), $urandom_range(0, 20), 1'($urandom));
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_two_operand_add();
        test_partial_then_complete();
        test_timeout();
        test_single_and_mul();
        test_reset_mid_collect();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
